// File: rtl/execute_port2_issue_queue_if.sv
// Bus bundle between the scheduler-side producer and the ALU2 issue queue.
// The master is the scheduler (and execute-port lock source); the slave is the queue.
interface execute_port2_issue_queue_if #(
   parameter int DEPTH_N = 2
);
   logic                iFREE_EX;
   logic                iSCHE_VALID;
   logic [95:0]         iSCHE_PAYLOAD;
   logic                oSCHE_LOCK;
   logic                oEX_ALU2_VALID;
   logic [95:0]         oEX_ALU2_PAYLOAD;
   logic                iEX_ALU2_LOCK;
   logic [DEPTH_N:0]    oCOUNT;

   modport master (
      output iFREE_EX,
      output iSCHE_VALID,
      output iSCHE_PAYLOAD,
      input  oSCHE_LOCK,
      input  oEX_ALU2_VALID,
      input  oEX_ALU2_PAYLOAD,
      output iEX_ALU2_LOCK,
      input  oCOUNT
   );

   modport slave (
      input  iFREE_EX,
      input  iSCHE_VALID,
      input  iSCHE_PAYLOAD,
      output oSCHE_LOCK,
      output oEX_ALU2_VALID,
      output oEX_ALU2_PAYLOAD,
      input  iEX_ALU2_LOCK,
      output oCOUNT
   );
endinterface

// File: rtl/execute_port2_issue_queue.sv
// ALU2 issue queue: in-order circular buffer between the scheduler's ALU2
// select and execute_port2. First-word fall-through on the execute side,
// back-pressure toward the scheduler, synchronous flush on iFREE_EX.
module execute_port2_issue_queue #(
   parameter int DEPTH   = 4,
   parameter int DEPTH_N = 2
) (
   input  logic                      iCLOCK,
   input  logic                      inRESET,
   execute_port2_issue_queue_if.slave bus
);

   localparam logic [DEPTH_N:0]   FULL_CNT = (DEPTH_N + 1)'(DEPTH);
   localparam logic [DEPTH_N-1:0] PTR_ONE  = DEPTH_N'(1);
   localparam logic [DEPTH_N:0]   CNT_ONE  = (DEPTH_N + 1)'(1);

   logic [95:0]        mem_q [DEPTH];
   logic [DEPTH_N-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_N-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_N:0]   count_q,  count_d;

   logic full;
   logic not_empty;
   logic sche_lock;
   logic push;
   logic pop;

   // Lock only looks at the registered count: a pop in the same cycle as a
   // full queue does not open a slot until the following cycle.
   assign full      = (count_q == FULL_CNT);
   assign not_empty = (count_q != '0);
   assign sche_lock = full | bus.iFREE_EX;
   assign push      = bus.iSCHE_VALID & ~sche_lock;
   assign pop       = not_empty & ~bus.iEX_ALU2_LOCK;

   assign bus.oSCHE_LOCK       = sche_lock;
   assign bus.oEX_ALU2_VALID   = not_empty;
   assign bus.oEX_ALU2_PAYLOAD = not_empty ? mem_q[rd_ptr_q] : '0;
   assign bus.oCOUNT           = count_q;

   // Next pointers and occupancy; flush wins over any same-cycle push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.iFREE_EX) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer/count registers; reset clears occupancy so outputs drop at once.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only observed while the entry is occupied.
   always_ff @(posedge iCLOCK) begin
      if (push) mem_q[wr_ptr_q] <= bus.iSCHE_PAYLOAD;
   end

endmodule

// File: tb/tb_execute_port2_issue_queue.sv
module tb_execute_port2_issue_queue;

   logic iCLOCK;
   logic inRESET;

   execute_port2_issue_queue_if #(.DEPTH_N(2)) bus ();

   execute_port2_issue_queue #(.DEPTH(4), .DEPTH_N(2)) dut (
      .iCLOCK  (iCLOCK),
      .inRESET (inRESET),
      .bus     (bus.slave)
   );

   initial iCLOCK = 1'b0;
   always #5 iCLOCK = ~iCLOCK;

   typedef struct {
      logic       sv;
      logic [5:0] tag;
      logic       el;
      logic       fe;
      logic       e_lock;
      logic       e_valid;
      logic [5:0] e_tag;
      logic [2:0] e_cnt;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Distinct payload per tag, tag placed in COMMIT_TAG[94:89].
   function automatic logic [95:0] mk(input logic [5:0] t);
      logic [95:0] p;
      p = {32'hDEAD0000 | {26'h0, t}, 32'hC0DE0000 ^ {26'h0, t}, 32'h5A5ABEEF ^ {t, 26'h0}};
      p[95]    = t[0];
      p[94:89] = t;
      return p;
   endfunction

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic e_lock, input logic e_valid,
                          input logic [5:0] e_tag, input logic [2:0] e_cnt);
      chk({nm, ".lock"},    96'(bus.oSCHE_LOCK),     96'(e_lock));
      chk({nm, ".valid"},   96'(bus.oEX_ALU2_VALID), 96'(e_valid));
      chk({nm, ".payload"}, bus.oEX_ALU2_PAYLOAD,    e_valid ? mk(e_tag) : 96'h0);
      chk({nm, ".count"},   96'(bus.oCOUNT),         96'(e_cnt));
   endtask

   task automatic add(input logic sv, input logic [5:0] tag, input logic el, input logic fe,
                      input logic e_lock, input logic e_valid, input logic [5:0] e_tag,
                      input logic [2:0] e_cnt);
      vec_t v;
      v.sv = sv; v.tag = tag; v.el = el; v.fe = fe;
      v.e_lock = e_lock; v.e_valid = e_valid; v.e_tag = e_tag; v.e_cnt = e_cnt;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic sv, input logic [5:0] tag, input logic el, input logic fe);
      bus.iSCHE_VALID   = sv;
      bus.iSCHE_PAYLOAD = mk(tag);
      bus.iEX_ALU2_LOCK = el;
      bus.iFREE_EX      = fe;
   endtask

   initial begin
      // Each row: inputs for one cycle; expectations are the outputs seen in
      // that cycle before its rising edge.
      //   sv  tag    el  fe   lock val  tag   cnt
      // single push then pop
      add(1, 6'd1, 0, 0,   0, 0, 6'd0, 3'd0);
      add(0, 6'd0, 0, 0,   0, 1, 6'd1, 3'd1);
      add(0, 6'd0, 0, 0,   0, 0, 6'd0, 3'd0);
      // fill under execute lock, fifth push refused, drain in order
      add(1, 6'd1, 1, 0,   0, 0, 6'd0, 3'd0);
      add(1, 6'd2, 1, 0,   0, 1, 6'd1, 3'd1);
      add(1, 6'd3, 1, 0,   0, 1, 6'd1, 3'd2);
      add(1, 6'd4, 1, 0,   0, 1, 6'd1, 3'd3);
      add(1, 6'd5, 1, 0,   1, 1, 6'd1, 3'd4);
      add(0, 6'd0, 0, 0,   1, 1, 6'd1, 3'd4);
      add(0, 6'd0, 0, 0,   0, 1, 6'd2, 3'd3);
      add(0, 6'd0, 0, 0,   0, 1, 6'd3, 3'd2);
      add(0, 6'd0, 0, 0,   0, 1, 6'd4, 3'd1);
      add(0, 6'd0, 0, 0,   0, 0, 6'd0, 3'd0);
      // full + pop + push same cycle: push refused, accepted next cycle
      add(1, 6'd10, 1, 0,  0, 0, 6'd0,  3'd0);
      add(1, 6'd11, 1, 0,  0, 1, 6'd10, 3'd1);
      add(1, 6'd12, 1, 0,  0, 1, 6'd10, 3'd2);
      add(1, 6'd13, 1, 0,  0, 1, 6'd10, 3'd3);
      add(1, 6'd14, 0, 0,  1, 1, 6'd10, 3'd4);
      add(1, 6'd14, 1, 0,  0, 1, 6'd11, 3'd3);
      add(0, 6'd0,  0, 0,  1, 1, 6'd11, 3'd4);
      add(0, 6'd0,  0, 0,  0, 1, 6'd12, 3'd3);
      // steady push & pop at COUNT=2 across pointer wrap
      for (int k = 0; k < 10; k++)
         add(1, 6'(20 + k), 0, 0, 0, 1, (k == 0) ? 6'd13 : (k == 1) ? 6'd14 : 6'(18 + k), 3'd2);
      add(0, 6'd0,  0, 0,  0, 1, 6'd28, 3'd2);
      add(0, 6'd0,  0, 0,  0, 1, 6'd29, 3'd1);
      // flush at COUNT=3 under execute lock with a push offered
      add(1, 6'd30, 1, 0,  0, 0, 6'd0,  3'd0);
      add(1, 6'd31, 1, 0,  0, 1, 6'd30, 3'd1);
      add(1, 6'd32, 1, 0,  0, 1, 6'd30, 3'd2);
      add(1, 6'd33, 1, 1,  1, 1, 6'd30, 3'd3);
      add(0, 6'd0,  0, 0,  0, 0, 6'd0,  3'd0);
      // queue usable after flush
      add(1, 6'd40, 0, 0,  0, 0, 6'd0,  3'd0);
      add(1, 6'd41, 0, 0,  0, 1, 6'd40, 3'd1);
      add(0, 6'd0,  0, 0,  0, 1, 6'd41, 3'd1);
      add(0, 6'd0,  0, 0,  0, 0, 6'd0,  3'd0);

      inRESET = 1'b0;
      drive(0, 6'd0, 0, 0);
      repeat (2) @(posedge iCLOCK);
      #1;
      chk_all("reset", 0, 0, 6'd0, 3'd0);
      @(negedge iCLOCK);
      inRESET = 1'b1;

      foreach (vecs[i]) begin
         @(posedge iCLOCK);
         #1;
         drive(vecs[i].sv, vecs[i].tag, vecs[i].el, vecs[i].fe);
         @(negedge iCLOCK);
         chk_all($sformatf("vec%0d", i), vecs[i].e_lock, vecs[i].e_valid,
                 vecs[i].e_tag, vecs[i].e_cnt);
      end

      // asynchronous reset in the middle of a cycle with two entries held
      @(posedge iCLOCK); #1; drive(1, 6'd50, 1, 0);
      @(posedge iCLOCK); #1; drive(1, 6'd51, 1, 0);
      @(posedge iCLOCK); #1; drive(1, 6'd52, 1, 0);
      @(negedge iCLOCK);
      chk_all("pre_async_rst", 0, 1, 6'd50, 3'd2);
      #1;
      inRESET = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 6'd0, 3'd0);
      @(negedge iCLOCK);
      chk_all("async_rst_hold", 0, 0, 6'd0, 3'd0);
      inRESET = 1'b1;
      drive(1, 6'd53, 0, 0);
      @(posedge iCLOCK); #1; drive(0, 6'd0, 0, 0);
      @(negedge iCLOCK);
      chk_all("post_rst_push", 0, 1, 6'd53, 3'd1);
      @(negedge iCLOCK);
      chk_all("post_rst_pop", 0, 0, 6'd0, 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
